// File: rtl/crossbar_master_queue.sv
// Request FIFO feeding one crossbar master port: buffers core requests and issues them one at a
// time on the master req/ack handshake. Define MQ_TIMEOUT_EN to add the ack-wait timeout.
module crossbar_master_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
`ifdef MQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_cmd,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_wdata,
    output logic                   resp_valid,
    output logic                   resp_cmd,
    output logic [DW-1:0]          resp_rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   master_req,
    output logic                   master_cmd,
    output logic [AW-1:0]          master_addr,
    output logic [DW-1:0]          master_wdata,
    input  logic [DW-1:0]          master_rdata,
    input  logic                   master_ack
`ifdef MQ_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q;
    logic            mem_cmd   [DEPTH];
    logic [AW-1:0]   mem_addr  [DEPTH];
    logic [DW-1:0]   mem_wdata [DEPTH];
    logic            push, pop, load, expire;

    // Registered count only, so a pop on the same edge never opens a slot early.
    assign in_ready = (count_q != FULL_LVL);
    assign level    = count_q;
    assign push     = in_valid && in_ready;

`ifdef MQ_TIMEOUT_EN
    localparam int unsigned   TW       = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StReq;
                    load    = 1'b1;
                end
            end
            StReq: begin
                // Ack on the expiry edge takes priority over the timeout.
                if (master_ack) begin
                    pop     = 1'b1;
                    state_d = StGap;
                end
`ifdef MQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    pop     = 1'b1;
                    expire  = 1'b1;
                    state_d = StGap;
                end
`endif
            end
            StGap: begin
                if (count_q != '0) begin
                    state_d = StReq;
                    load    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_cmd[wr_ptr_q]   <= in_cmd;
            mem_addr[wr_ptr_q]  <= in_addr;
            mem_wdata[wr_ptr_q] <= in_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            master_req   <= 1'b0;
            master_cmd   <= 1'b0;
            master_addr  <= '0;
            master_wdata <= '0;
            resp_valid   <= 1'b0;
            resp_cmd     <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop) begin
                count_q <= count_q + (PW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW + 1)'(1);
            end
            if (load) begin
                master_req   <= 1'b1;
                master_cmd   <= mem_cmd[rd_ptr_q];
                master_addr  <= mem_addr[rd_ptr_q];
                master_wdata <= mem_wdata[rd_ptr_q];
            end else if (pop) begin
                master_req <= 1'b0;
            end
            resp_valid <= pop;
            if (pop) begin
                resp_cmd   <= master_cmd;
                resp_rdata <= (master_cmd || expire) ? '0 : master_rdata;
            end
        end
    end

`ifdef MQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (load) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StReq) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_crossbar_master_queue.sv
// Bench for crossbar_master_queue: transaction-level queue model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. Honors MQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_crossbar_master_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
`ifdef MQ_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 8;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_cmd = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_wdata = '0;
    logic          resp_valid;
    logic          resp_cmd;
    logic [DW-1:0] resp_rdata;
    logic [2:0]    level;
    logic          master_req;
    logic          master_cmd;
    logic [AW-1:0] master_addr;
    logic [DW-1:0] master_wdata;
    logic [DW-1:0] master_rdata = '0;
    logic          master_ack = 1'b0;
`ifdef MQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    crossbar_master_queue #(
        .DEPTH(DEPTH),
        .AW(AW),
        .DW(DW)
`ifdef MQ_TIMEOUT_EN
        ,
        .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_cmd(in_cmd),
        .in_addr(in_addr),
        .in_wdata(in_wdata),
        .resp_valid(resp_valid),
        .resp_cmd(resp_cmd),
        .resp_rdata(resp_rdata),
        .level(level),
        .master_req(master_req),
        .master_cmd(master_cmd),
        .master_addr(master_addr),
        .master_wdata(master_wdata),
        .master_rdata(master_rdata),
        .master_ack(master_ack)
`ifdef MQ_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } ent_t;

    // Model: q[0] is the head (in flight while m_req); m_hi = cycles req has been high.
    ent_t          q[$];
    logic          m_req = 1'b0;
    logic          m_rv = 1'b0;
    logic          m_rcmd = 1'b0;
    logic          m_terr = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int            m_hi = 0;

    int checks = 0;
    int failures = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   push;
        bit   done;
        bit   tmo;
        bit   nreq;
        ent_t e;
        push = in_valid && (q.size() < DEPTH);
        done = 1'b0;
        tmo  = 1'b0;
        if (m_req) begin
            if (master_ack) done = 1'b1;
`ifdef MQ_TIMEOUT_EN
            else if (m_hi == TIMEOUT) begin
                done = 1'b1;
                tmo  = 1'b1;
            end
`endif
        end
        m_rv   = done;
        m_terr = tmo;
        if (done) begin
            m_rcmd  = q[0].cmd;
            m_rdata = (q[0].cmd || tmo) ? '0 : master_rdata;
        end
        nreq = m_req ? !done : (q.size() > 0);
        if (done) void'(q.pop_front());
        if (push) begin
            e.cmd   = in_cmd;
            e.addr  = in_addr;
            e.wdata = in_wdata;
            q.push_back(e);
        end
        m_hi  = nreq ? (m_req ? m_hi + 1 : 1) : 0;
        m_req = nreq;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                m_req  = 1'b0;
                m_rv   = 1'b0;
                m_terr = 1'b0;
                m_hi   = 0;
            end else begin
                model_step();
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("level", 64'(level), 64'(q.size()));
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("master_req", 64'(master_req), 64'(m_req));
            if (m_req && q.size() > 0) begin
                chk("master_cmd", 64'(master_cmd), 64'(q[0].cmd));
                chk("master_addr", 64'(master_addr), 64'(q[0].addr));
                chk("master_wdata", 64'(master_wdata), 64'(q[0].wdata));
            end
            chk("resp_valid", 64'(resp_valid), 64'(m_rv));
            if (m_rv) begin
                chk("resp_cmd", 64'(resp_cmd), 64'(m_rcmd));
                chk("resp_rdata", 64'(resp_rdata), 64'(m_rdata));
            end
`ifdef MQ_TIMEOUT_EN
            chk("timeout_err", 64'(timeout_err), 64'(m_terr));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = v;
        in_cmd   = c;
        in_addr  = a;
        in_wdata = d;
    endtask

    task automatic wait_req(input int max, input string name);
        int n;
        n = 0;
        while (!master_req && n < max) begin
            tick();
            n++;
        end
        chk(name, 64'(master_req), 64'd1);
    endtask

    initial begin
        logic [9:0] pat;
        int         pulses;
        int         n;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        run_chk = 1'b1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_req", 64'(master_req), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        tick();

        // Single write: push at edge 0, req after edge 1, ack sampled at edge 3.
        drive(1'b1, 1'b1, 32'h0000_ADD0, 32'h000F_EED0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        chk("t1_req_e0", 64'(master_req), 64'd0);
        chk("t1_level_e0", 64'(level), 64'd1);
        tick();
        chk("t1_req_e1", 64'(master_req), 64'd1);
        chk("t1_cmd", 64'(master_cmd), 64'd1);
        chk("t1_addr", 64'(master_addr), 64'h0000_ADD0);
        chk("t1_wdata", 64'(master_wdata), 64'h000F_EED0);
        tick();
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_resp_cmd", 64'(resp_cmd), 64'd1);
        chk("t1_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("t1_req_drop", 64'(master_req), 64'd0);
        tick();
        chk("t1_resp_pulse", 64'(resp_valid), 64'd0);
        repeat (2) tick();

        // Single read.
        drive(1'b1, 1'b0, 32'h8000_ADD1, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        wait_req(5, "t2_req");
        master_ack   = 1'b1;
        master_rdata = 32'hFEED_00C1;
        tick();
        master_ack   = 1'b0;
        master_rdata = '0;
        chk("t2_resp_valid", 64'(resp_valid), 64'd1);
        chk("t2_resp_cmd", 64'(resp_cmd), 64'd0);
        chk("t2_resp_rdata", 64'(resp_rdata), 64'hFEED_00C1);
        tick();
        chk("t2_resp_pulse", 64'(resp_valid), 64'd0);
        repeat (2) tick();

        // Fill: fifth push is refused, drain returns in push order.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'(i), 32'(32'hA0 + i));
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        chk("t3_level_full", 64'(level), 64'd4);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            wait_req(10, "t3_req");
            chk("t3_order", 64'(master_addr), 64'(i));
            master_ack = 1'b1;
            tick();
            master_ack = 1'b0;
            chk("t3_resp", 64'(resp_valid), 64'd1);
        end
        repeat (3) tick();
        chk("t3_empty", 64'(level), 64'd0);

        // Back-to-back with ack held high.
        master_ack = 1'b1;
        pat = '0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) drive(1'b1, 1'b1, 32'(32'h400 + i), 32'(i));
            else drive(1'b0, 1'b0, '0, '0);
            tick();
            pat[i] = master_req;
            if (resp_valid) pulses++;
        end
        master_ack = 1'b0;
        chk("t4_req_pattern", 64'(pat), 64'h02A);
        chk("t4_resp_pulses", 64'(pulses), 64'd3);
        repeat (2) tick();

        // Asynchronous reset while a request is in flight.
        drive(1'b1, 1'b0, 32'h0000_0005, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        wait_req(5, "t5_req");
        #2 reset = 1'b0;
        #1;
        chk("t5_req_async", 64'(master_req), 64'd0);
        chk("t5_level_async", 64'(level), 64'd0);
        chk("t5_in_ready_async", 64'(in_ready), 64'd1);
        chk("t5_resp_async", 64'(resp_valid), 64'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        pulses = 0;
        repeat (6) begin
            tick();
            if (resp_valid) pulses++;
        end
        chk("t5_no_resp", 64'(pulses), 64'd0);
        chk("t5_level_after", 64'(level), 64'd0);

`ifdef MQ_TIMEOUT_EN
        // Timeout with no ack, next entry issues, then ack on the expiry edge wins.
        master_rdata = 32'hDEAD_BEEF;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'(32'h600 + i), '0);
            tick();
            if (master_req) n++;
        end
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 20 && master_req; i++) begin
            tick();
            if (master_req) n++;
        end
        chk("t6_req_cycles", 64'(n), 64'd8);
        chk("t6_resp_valid", 64'(resp_valid), 64'd1);
        chk("t6_timeout_err", 64'(timeout_err), 64'd1);
        chk("t6_resp_rdata", 64'(resp_rdata), 64'd0);
        tick();
        chk("t6_next_req", 64'(master_req), 64'd1);
        chk("t6_next_addr", 64'(master_addr), 64'h601);
        repeat (7) tick();
        master_ack   = 1'b1;
        master_rdata = 32'h5A5A_0002;
        tick();
        master_ack = 1'b0;
        chk("t6_ack_wins_valid", 64'(resp_valid), 64'd1);
        chk("t6_ack_wins_err", 64'(timeout_err), 64'd0);
        chk("t6_ack_wins_rdata", 64'(resp_rdata), 64'h5A5A_0002);
        wait_req(5, "t6_third_req");
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        repeat (3) tick();
`endif

        // Random traffic in three ack-rate phases (slow acks also drive the queue full).
        for (int ph = 0; ph < 3; ph++) begin
            int pa;
            pa = (ph == 0) ? 50 : ((ph == 1) ? 90 : 4);
            for (int c = 0; c < 1500; c++) begin
                in_valid     = ($urandom_range(0, 99) < 60);
                in_cmd       = 1'($urandom_range(0, 1));
                in_addr      = $urandom;
                in_wdata     = $urandom;
                master_ack   = ($urandom_range(0, 99) < pa);
                master_rdata = $urandom;
                tick();
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        master_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
